audio_codec_i2s_master: RTL and testbench

//  Codec-side end of the DE2-70 audio serial link: generates BCLK/ADCLRC/DACLRC from avs_s1_clk,

---
 rtl/audio_codec_i2s_master_pkg.sv | 24 ++
 rtl/audio_codec_i2s_master_if.sv | 23 ++
 rtl/audio_codec_i2s_master_bclk_gen.sv | 60 ++++++
 rtl/audio_codec_i2s_master.sv | 142 ++++++++++++++
 tb/tb_audio_codec_i2s_master.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/audio_codec_i2s_master_pkg.sv
// Shared I2S link types and defaults for the codec-side audio serial master.
package audio_codec_i2s_master_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 16;
    localparam int unsigned DEF_SLOT_BITS  = 32;
    localparam int unsigned DEF_BCLK_DIV   = 4;

    typedef enum logic {
        LRC_LEFT  = 1'b0,
        LRC_RIGHT = 1'b1
    } lrc_e;

    typedef enum logic {
        BG_IDLE = 1'b0,
        BG_RUN  = 1'b1
    } bclk_state_e;

    // Slot bit positions 1..data_width carry sample bits, MSB first.
    function automatic logic in_data_window(input int unsigned bit_idx,
                                            input int unsigned data_width);
        return (bit_idx >= 1) && (bit_idx <= data_width);
    endfunction

endpackage

// File: rtl/audio_codec_i2s_master_if.sv
// Stereo frame exchange between the I2S master and local logic.
interface audio_codec_i2s_master_if #(
    parameter int unsigned DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] tx_left;
    logic [DATA_WIDTH-1:0] tx_right;
    logic                  tx_valid;
    logic                  tx_ready;
    logic                  tx_underrun;
    logic [DATA_WIDTH-1:0] rx_left;
    logic [DATA_WIDTH-1:0] rx_right;
    logic                  rx_valid;

    modport master (
        input  tx_left, tx_right, tx_valid,
        output tx_ready, tx_underrun, rx_left, rx_right, rx_valid
    );

    modport slave (
        output tx_left, tx_right, tx_valid,
        input  tx_ready, tx_underrun, rx_left, rx_right, rx_valid
    );
endinterface

// File: rtl/audio_codec_i2s_master_bclk_gen.sv
// BCLK divider with run/idle control; rise/fall ticks flag the edge on which BCLK toggles.
module audio_codec_i2s_master_bclk_gen
    import audio_codec_i2s_master_pkg::*;
#(
    parameter int unsigned BCLK_DIV = DEF_BCLK_DIV
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_enable,
    input  logic i_stop,
    output logic o_bclk,
    output logic o_rise,
    output logic o_fall
);
    localparam int unsigned     DIV_W    = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

    bclk_state_e      r_state;
    bclk_state_e      w_state_nxt;
    logic [DIV_W-1:0] r_div_cnt;
    logic             r_bclk;
    logic             w_tick;

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= BG_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            BG_IDLE: if (i_enable) w_state_nxt = BG_RUN;
            BG_RUN:  if (i_stop)   w_state_nxt = BG_IDLE;
            default: w_state_nxt = BG_IDLE;
        endcase
    end

    always_comb begin
        w_tick = (r_state == BG_RUN) && (r_div_cnt == DIV_LAST);
        o_rise = w_tick && !r_bclk;
        o_fall = w_tick && r_bclk;
        o_bclk = r_bclk;
    end

    // A stop always coincides with a fall tick, so BCLK parks low.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_div_cnt <= '0;
            r_bclk    <= 1'b0;
        end else if (w_tick) begin
            r_div_cnt <= '0;
            r_bclk    <= ~r_bclk;
        end else if (r_state == BG_RUN) begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end else begin
            r_div_cnt <= '0;
            r_bclk    <= 1'b0;
        end
    end
endmodule

// File: rtl/audio_codec_i2s_master.sv
// I2S master: slot/bit counters, ADC serialiser, DAC deserialiser and frame handshakes.
module audio_codec_i2s_master
    import audio_codec_i2s_master_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned SLOT_BITS  = DEF_SLOT_BITS,
    parameter int unsigned BCLK_DIV   = DEF_BCLK_DIV
) (
    input  logic avs_s1_clk,
    input  logic avs_s1_reset,
    input  logic enable,
    output logic avs_s1_export_BCLK,
    output logic avs_s1_export_ADCLRC,
    output logic avs_s1_export_DACLRC,
    output logic avs_s1_export_ADCDAT,
    input  logic avs_s1_export_DACDAT,
    audio_codec_i2s_master_if.master s_if
);
    localparam int unsigned BIT_W = (SLOT_BITS > 1) ? $clog2(SLOT_BITS) : 1;
    typedef logic [BIT_W-1:0]      bit_t;
    typedef logic [DATA_WIDTH-1:0] sample_t;
    localparam bit_t BIT_LAST = bit_t'(SLOT_BITS - 1);

    logic    w_rise, w_fall, w_bclk, w_lrc;
    logic    w_slot_end, w_frame_start, w_stop, w_data_nxt, w_data_cur;
    bit_t    r_bit_cnt, w_bit_nxt;
    lrc_e    r_ch, w_ch_nxt;
    sample_t r_sh_left, r_sh_right, r_cap_left, r_cap_right, r_rx_left, r_rx_right;
    logic    r_adcdat, r_tx_ready, r_tx_underrun, r_rx_valid, r_first_frame;

    audio_codec_i2s_master_bclk_gen #(.BCLK_DIV(BCLK_DIV)) u_bclk_gen (
        .i_clk    (avs_s1_clk),
        .i_rst    (avs_s1_reset),
        .i_enable (enable),
        .i_stop   (w_stop),
        .o_bclk   (w_bclk),
        .o_rise   (w_rise),
        .o_fall   (w_fall)
    );

    always_comb begin
        w_slot_end    = (r_bit_cnt == BIT_LAST);
        w_bit_nxt     = w_slot_end ? '0 : r_bit_cnt + 1'b1;
        w_frame_start = w_fall && w_slot_end && (r_ch == LRC_RIGHT);
        w_stop        = w_frame_start && !enable;
        w_data_nxt    = in_data_window(32'(w_bit_nxt), DATA_WIDTH);
        w_data_cur    = in_data_window(32'(r_bit_cnt), DATA_WIDTH);
    end

    always_ff @(posedge avs_s1_clk) begin
        if (avs_s1_reset) r_ch <= LRC_RIGHT;
        else              r_ch <= w_ch_nxt;
    end

    // Stopping parks the link in the pre-frame state (right slot, last bit) so a restart matches reset.
    always_comb begin
        w_ch_nxt = r_ch;
        if (w_stop)
            w_ch_nxt = LRC_RIGHT;
        else if (w_fall && w_slot_end)
            w_ch_nxt = (r_ch == LRC_LEFT) ? LRC_RIGHT : LRC_LEFT;
    end

    always_comb begin
        w_lrc = (r_ch == LRC_RIGHT);
    end

    always_ff @(posedge avs_s1_clk) begin
        if (avs_s1_reset || w_stop) r_bit_cnt <= BIT_LAST;
        else if (w_fall)            r_bit_cnt <= w_bit_nxt;
    end

    always_ff @(posedge avs_s1_clk) begin
        if (avs_s1_reset) begin
            r_sh_left     <= '0;
            r_sh_right    <= '0;
            r_adcdat      <= 1'b0;
            r_tx_ready    <= 1'b0;
            r_tx_underrun <= 1'b0;
        end else begin
            r_tx_ready    <= 1'b0;
            r_tx_underrun <= 1'b0;
            if (w_frame_start && enable) begin
                r_adcdat <= 1'b0;
                if (s_if.tx_valid) begin
                    r_sh_left  <= s_if.tx_left;
                    r_sh_right <= s_if.tx_right;
                    r_tx_ready <= 1'b1;
                end else begin
                    r_sh_left     <= '0;
                    r_sh_right    <= '0;
                    r_tx_underrun <= 1'b1;
                end
            end else if (w_fall) begin
                if (!w_data_nxt) begin
                    r_adcdat <= 1'b0;
                end else if (w_ch_nxt == LRC_LEFT) begin
                    r_adcdat  <= r_sh_left[DATA_WIDTH-1];
                    r_sh_left <= r_sh_left << 1;
                end else begin
                    r_adcdat   <= r_sh_right[DATA_WIDTH-1];
                    r_sh_right <= r_sh_right << 1;
                end
            end
        end
    end

    always_ff @(posedge avs_s1_clk) begin
        if (avs_s1_reset) begin
            r_cap_left    <= '0;
            r_cap_right   <= '0;
            r_rx_left     <= '0;
            r_rx_right    <= '0;
            r_rx_valid    <= 1'b0;
            r_first_frame <= 1'b1;
        end else begin
            r_rx_valid <= 1'b0;
            if (w_rise && w_data_cur) begin
                if (r_ch == LRC_LEFT) r_cap_left  <= (r_cap_left  << 1) | sample_t'(avs_s1_export_DACDAT);
                else                  r_cap_right <= (r_cap_right << 1) | sample_t'(avs_s1_export_DACDAT);
            end
            if (w_frame_start) begin
                if (!r_first_frame) begin
                    r_rx_left  <= r_cap_left;
                    r_rx_right <= r_cap_right;
                    r_rx_valid <= 1'b1;
                end
                r_first_frame <= !enable;
            end
        end
    end

    assign avs_s1_export_BCLK   = w_bclk;
    assign avs_s1_export_ADCLRC = w_lrc;
    assign avs_s1_export_DACLRC = w_lrc;
    assign avs_s1_export_ADCDAT = r_adcdat;
    assign s_if.tx_ready        = r_tx_ready;
    assign s_if.tx_underrun     = r_tx_underrun;
    assign s_if.rx_left         = r_rx_left;
    assign s_if.rx_right        = r_rx_right;
    assign s_if.rx_valid        = r_rx_valid;
endmodule

// File: tb/tb_audio_codec_i2s_master.sv
// Randomised bench for audio_codec_i2s_master: frame-timing reference model plus rx scoreboard.
module tb_audio_codec_i2s_master;
    localparam int DW    = 16;
    localparam int SB    = 32;
    localparam int DIV   = 2;
    localparam int HB    = 2 * DIV;
    localparam int FRAME = 2 * SB * HB;

    logic clk    = 1'b0;
    logic rst    = 1'b1;
    logic enable = 1'b0;
    logic dacdat = 1'b0;
    logic bclk, adclrc, daclrc, adcdat;

    audio_codec_i2s_master_if #(.DATA_WIDTH(DW)) u_if ();

    audio_codec_i2s_master #(.DATA_WIDTH(DW), .SLOT_BITS(SB), .BCLK_DIV(DIV)) dut (
        .avs_s1_clk           (clk),
        .avs_s1_reset         (rst),
        .enable               (enable),
        .avs_s1_export_BCLK   (bclk),
        .avs_s1_export_ADCLRC (adclrc),
        .avs_s1_export_DACLRC (daclrc),
        .avs_s1_export_ADCDAT (adcdat),
        .avs_s1_export_DACDAT (dacdat),
        .s_if                 (u_if.master)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int valid_mode  = 0;
    bit loop        = 1'b0;
    logic [31:0] dir_q[$];
    logic [31:0] rx_q[$];

    // Reference model: m_t counts clocks since the link started running.
    bit            m_seen_rst  = 1'b0;
    bit            m_run       = 1'b0;
    bit            m_have_prev = 1'b0;
    int            m_t         = 0;
    logic [DW-1:0] m_tx [2]    = '{16'h0, 16'h0};
    logic [DW-1:0] m_dac [2]   = '{16'h0, 16'h0};
    bit            e_ready = 1'b0, e_under = 1'b0, e_rxv = 1'b0;

    function automatic int frame_pos();
        if (!m_run || m_t < HB) return -1;
        return ((m_t - HB) % FRAME) / HB;
    endfunction

    function automatic logic [6:0] exp_pins();
        logic bc, lr, ad;
        int   p, b, ch;
        bc = 1'b0; lr = 1'b1; ad = 1'b0;
        if (m_run) begin
            bc = ((m_t % HB) >= DIV);
            p  = frame_pos();
            if (p >= 0) begin
                b  = p % SB;
                ch = p / SB;
                lr = (ch == 1);
                if (b >= 1 && b <= DW) ad = m_tx[ch][DW-b];
            end
        end
        return {bc, lr, lr, ad, e_ready, e_under, e_rxv};
    endfunction

    always @(posedge clk) begin
        e_ready = 1'b0; e_under = 1'b0; e_rxv = 1'b0;
        if (rst) begin
            m_seen_rst  = 1'b1;
            m_run       = 1'b0;
            m_t         = 0;
            m_have_prev = 1'b0;
        end else if (!m_run) begin
            if (enable) begin
                m_run = 1'b1;
                m_t   = 0;
            end
        end else begin
            m_t++;
            if (m_t >= HB && (m_t - HB) % FRAME == 0) begin
                if (m_have_prev) begin
                    rx_q.push_back({m_dac[0], m_dac[1]});
                    e_rxv = 1'b1;
                end
                if (!enable) begin
                    m_run       = 1'b0;
                    m_have_prev = 1'b0;
                end else begin
                    if (u_if.tx_valid) begin
                        m_tx[0] = u_if.tx_left;
                        m_tx[1] = u_if.tx_right;
                        e_ready = 1'b1;
                    end else begin
                        m_tx[0] = '0;
                        m_tx[1] = '0;
                        e_under = 1'b1;
                    end
                    if (loop) m_dac = m_tx;
                    else begin
                        m_dac[0] = 16'($urandom);
                        m_dac[1] = 16'($urandom);
                    end
                    m_have_prev = 1'b1;
                end
            end
        end
    end

    logic [6:0] pin_act, pin_exp;
    always @(negedge clk) begin
        if (m_seen_rst) begin
            pin_act = {bclk, adclrc, daclrc, adcdat, u_if.tx_ready, u_if.tx_underrun, u_if.rx_valid};
            pin_exp = exp_pins();
            vectors++;
            if (pin_act !== pin_exp) begin
                miscompares++;
                $display("FAIL pins @%0t: got %b want %b (bclk adclrc daclrc adcdat tx_ready tx_underrun rx_valid)",
                         $time, pin_act, pin_exp);
            end
        end
    end

    logic [31:0] rx_exp;
    always @(negedge clk) begin
        if (m_seen_rst && u_if.rx_valid === 1'b1) begin
            vectors++;
            if (rx_q.size() == 0) begin
                miscompares++;
                $display("FAIL rx_unexpected @%0t: got %h/%h want no frame", $time, u_if.rx_left, u_if.rx_right);
            end else begin
                rx_exp = rx_q.pop_front();
                if ({u_if.rx_left, u_if.rx_right} !== rx_exp) begin
                    miscompares++;
                    $display("FAIL rx_frame @%0t: got %h/%h want %h/%h", $time,
                             u_if.rx_left, u_if.rx_right, rx_exp[31:16], rx_exp[15:0]);
                end
            end
        end
    end

    // DAC stimulus: model frame words inside the data window, random filler elsewhere.
    int dac_p;
    always @(negedge clk) begin
        dac_p  = frame_pos();
        dacdat = 1'($urandom_range(0, 1));
        if (dac_p >= 0 && (dac_p % SB) >= 1 && (dac_p % SB) <= DW)
            dacdat = m_dac[dac_p / SB][DW - (dac_p % SB)];
    end

    always @(negedge clk) begin
        if (u_if.tx_ready === 1'b1 && u_if.tx_valid && dir_q.size() > 0) void'(dir_q.pop_front());
        if (dir_q.size() > 0) begin
            {u_if.tx_left, u_if.tx_right} = dir_q[0];
        end else begin
            u_if.tx_left  = 16'($urandom);
            u_if.tx_right = 16'($urandom);
        end
        case (valid_mode)
            0:       u_if.tx_valid = 1'b0;
            1:       u_if.tx_valid = 1'b1;
            default: u_if.tx_valid = ($urandom_range(0, 3) != 0);
        endcase
    end

    task automatic wait_slot(input int want_ch, input int want_b, input int limit, input string name);
        bit found;
        int p;
        found = 1'b0;
        for (int i = 0; i < limit && !found; i++) begin
            @(negedge clk);
            p = frame_pos();
            if (p >= 0 && p / SB == want_ch && p % SB == want_b) found = 1'b1;
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL %s: got timeout after %0d clk want slot %0d bit %0d", name, limit, want_ch, want_b);
        end
    endtask

    task automatic wait_dir_empty(input int limit);
        bit done;
        done = 1'b0;
        for (int i = 0; i < limit && !done; i++) begin
            @(negedge clk);
            if (dir_q.size() == 0) done = 1'b1;
        end
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL tx_directed: got %0d frames unconsumed want 0", dir_q.size());
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (5) @(negedge clk);
        vectors++;
        if ({u_if.rx_left, u_if.rx_right} !== 32'h0) begin
            miscompares++;
            $display("FAIL rx_reset: got %h/%h want 0000/0000", u_if.rx_left, u_if.rx_right);
        end
        rst = 1'b0;
        repeat (1000) @(negedge clk);

        dir_q.push_back({16'hA5C3, 16'h0F01});
        dir_q.push_back({16'h8000, 16'h7FFF});
        dir_q.push_back({16'h1234, 16'hFFFF});
        valid_mode = 1;
        loop       = 1'b1;
        enable     = 1'b1;
        wait_dir_empty(4 * FRAME);
        repeat (FRAME + 20) @(negedge clk);

        valid_mode = 0;
        repeat (FRAME + 40) @(negedge clk);
        valid_mode = 2;
        loop       = 1'b0;
        repeat (4 * FRAME + 50) @(negedge clk);

        wait_slot(0, 10, 2 * FRAME, "enable_drop_wait");
        enable = 1'b0;
        repeat (2 * FRAME + 100) @(negedge clk);
        enable     = 1'b1;
        valid_mode = 1;
        loop       = 1'b1;
        repeat (3 * FRAME) @(negedge clk);

        wait_slot(1, 5, 2 * FRAME, "reset_wait");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        valid_mode = 2;
        repeat (3 * FRAME) @(negedge clk);
        enable = 1'b0;
        repeat (2 * FRAME + 20) @(negedge clk);

        vectors++;
        if (rx_q.size() != 0) begin
            miscompares++;
            $display("FAIL rx_drain: got %0d unreported frames want 0", rx_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
